vga_key_ctrl: RTL and testbench
===============================

# vga_key_ctrl

Debounced push-button front end for the VGA pattern generator. It sits directly upstream of the VGA stage's KEYA input. It converts the raw, bouncing, active-low board key into a clean level, a single-cycle press pulse and a pattern-select counter, which the VGA stage consumes to change its displayed colour pattern. It also flags long presses, which return the pattern select to 0.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- LONG_CYCLES, default 50000000: held cycles after press acceptance that make a long press; must exceed DEBOUNCE_CYCLES.
- NUM_MODES, default 4: number of pattern-select values; minimum 2.

Ports:
- CLK, input, 1: single system clock; all logic on the rising edge.
- RESET, input, 1: synchronous, active-high reset.
- KEY_IN, input, 1: raw board key, asynchronous, active-low (0 = pressed).
- KEY_LEVEL, output, 1: debounced key state (1 = pressed).
- PRESS_PULSE, output, 1: one-cycle pulse per accepted press.
- LONG_PRESS, output, 1: one-cycle pulse when a held press reaches LONG_CYCLES.
- MODE, output, MODE_W = max(1, clog2(NUM_MODES)): current pattern select, consumed by the VGA stage.

## Operation
- **Synchronizer:** KEY_IN passes through two flops (sync1, sync2); the FSM uses only sync2 (s). Both flops reset to 1 (released).
- **Counters:**
  - Debounce counter: clog2(DEBOUNCE_CYCLES) bits.
  - Hold counter: clog2(LONG_CYCLES) bits; saturates and never wraps.
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: if s==0, go to PRESS_WAIT and clear cnt.
  - PRESS_WAIT:
    - s==1: return to IDLE; no output change.
    - s==0 and cnt < DEBOUNCE_CYCLES-1: cnt++.
    - s==0 and cnt == DEBOUNCE_CYCLES-1: go to PRESSED. PRESS_PULSE=1 for one cycle, KEY_LEVEL=1, MODE advances, hold counter clears.
  - PRESSED:
    - s==1: go to RELEASE_WAIT and clear cnt.
    - Otherwise the hold counter increments. When it equals LONG_CYCLES-1: LONG_PRESS=1 for one cycle and MODE←0. Fires once per press.
  - RELEASE_WAIT:
    - s==0: return to PRESSED. No new PRESS_PULSE; hold counter and long-press-fired flag are kept.
    - s==1 for DEBOUNCE_CYCLES consecutive cycles: go to IDLE, KEY_LEVEL=0.
- **MODE advance:** MODE ← (MODE == NUM_MODES-1) ? 0 : MODE+1.
- **Simultaneous events:** LONG_PRESS has priority over any other MODE write; the two cannot coincide in legal operation.
- **Bounce:** a glitch shorter than DEBOUNCE_CYCLES never produces a pulse.

## Timing
- **Reset:** on the edge where RESET=1:
  - state=IDLE, counters=0, sync1=sync2=1.
  - KEY_LEVEL=0, PRESS_PULSE=0, LONG_PRESS=0, MODE=0.
  - RESET overrides everything, including mid-PRESS_WAIT and mid-PRESSED. No pulse is emitted on or after reset until a fresh, fully debounced press.
- **Press latency:** count the rising edge that first samples KEY_IN=0 as edge 1. PRESS_PULSE, KEY_LEVEL and the new MODE are registered on edge DEBOUNCE_CYCLES+3, provided KEY_IN stays low throughout.
- **Pulse width:** PRESS_PULSE and LONG_PRESS are high for exactly one cycle.
- **Long-press latency:** LONG_PRESS is registered LONG_CYCLES edges after the PRESS_PULSE edge, if there has been no debounced release.
- **Release latency:** KEY_LEVEL falls on edge DEBOUNCE_CYCLES+3, counting the first edge that samples KEY_IN=1 as edge 1.
- **Registration:** all outputs are registered; there is no combinational path from KEY_IN.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, NUM_MODES=4.
- **Reset:** hold RESET=1 for 3 cycles with KEY_IN=0 → all outputs 0 and MODE=0. Release RESET → first PRESS_PULSE arrives exactly 7 edges later.
- **Clean press:** KEY_IN low from edge 1, held for 10 cycles → PRESS_PULSE high only after edge 7, KEY_LEVEL=1 and MODE=1 from edge 7.
- **Bounce:** KEY_IN low 3 cycles, high 1, low 2, high → no PRESS_PULSE, MODE unchanged. Then a clean 4-cycle bounce during release → KEY_LEVEL stays 1 and no second pulse.
- **Wrap:** 5 clean press/release cycles from reset → MODE sequence 1, 2, 3, 0, 1; exactly 5 PRESS_PULSEs.
- **Long press:** hold KEY_IN low for 40 cycles with MODE=2 → after the press MODE=3; LONG_PRESS pulses once, 20 edges after PRESS_PULSE; MODE=0 thereafter; no further pulses while held.
- **Reset mid-operation:** assert RESET during PRESSED with MODE=2, deassert while KEY_IN is still low → MODE=0 and KEY_LEVEL=0, then a new PRESS_PULSE 7 edges later with MODE=1.

Source files
------------

// File: rtl/vga_key_ctrl.sv
// Debounced active-low push-button front end for the VGA pattern generator:
// clean level, one-cycle press pulse, long-press pulse and a wrapping mode select.
module vga_key_ctrl #(
  parameter int unsigned  DEBOUNCE_CYCLES = 500000,
  parameter int unsigned  LONG_CYCLES     = 50000000,
  parameter int unsigned  NUM_MODES       = 4,
  localparam int unsigned MODE_W          = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              KEY_IN,
  output logic              KEY_LEVEL,
  output logic              PRESS_PULSE,
  output logic              LONG_PRESS,
  output logic [MODE_W-1:0] MODE
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [DB_W-1:0]     cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                fired_q, fired_d;
  logic                key_level_q, key_level_d;
  logic                press_pulse_q, press_pulse_d;
  logic                long_press_q, long_press_d;
  logic [MODE_W-1:0]   mode_q, mode_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      cnt_q         <= '0;
      hold_q        <= '0;
      fired_q       <= 1'b0;
      key_level_q   <= 1'b0;
      press_pulse_q <= 1'b0;
      long_press_q  <= 1'b0;
      mode_q        <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      fired_q       <= fired_d;
      key_level_q   <= key_level_d;
      press_pulse_q <= press_pulse_d;
      long_press_q  <= long_press_d;
      mode_q        <= mode_d;
    end
  end

  always_comb begin
    sync1_d       = KEY_IN;
    sync2_d       = sync1_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    fired_d       = fired_q;
    key_level_d   = key_level_q;
    press_pulse_d = 1'b0;
    long_press_d  = 1'b0;
    mode_d        = mode_q;

    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d       = PRESSED;
          press_pulse_d = 1'b1;
          key_level_d   = 1'b1;
          mode_d        = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
          hold_d        = '0;
          fired_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          // hold counter parks here; fired flag limits the pulse to one per press
          if (!fired_q) begin
            long_press_d = 1'b1;
            mode_d       = '0;
            fired_d      = 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d     = IDLE;
          key_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign KEY_LEVEL   = key_level_q;
  assign PRESS_PULSE = press_pulse_q;
  assign LONG_PRESS  = long_press_q;
  assign MODE        = mode_q;

endmodule

// File: tb/tb_vga_key_ctrl.sv
// Scoreboard bench for vga_key_ctrl with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, NUM_MODES=4.
module tb_vga_key_ctrl;

  localparam int DB    = 4;
  localparam int LONG  = 20;
  localparam int NMODE = 4;
  localparam int EV_PRESS = 1;
  localparam int EV_LONG  = 2;

  typedef struct {
    int kind;
    int cyc;
    int mode;
  } ev_t;

  logic       clk;
  logic       RESET;
  logic       KEY_IN;
  logic       KEY_LEVEL;
  logic       PRESS_PULSE;
  logic       LONG_PRESS;
  logic [1:0] MODE;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc;
  int  n_checks;
  int  n_fail;

  vga_key_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LONG),
    .NUM_MODES(NMODE)
  ) dut (
    .CLK(clk),
    .RESET(RESET),
    .KEY_IN(KEY_IN),
    .KEY_LEVEL(KEY_LEVEL),
    .PRESS_PULSE(PRESS_PULSE),
    .LONG_PRESS(LONG_PRESS),
    .MODE(MODE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (PRESS_PULSE === 1'b1) obs_q.push_back('{EV_PRESS, cyc, int'(MODE)});
    if (LONG_PRESS === 1'b1) obs_q.push_back('{EV_LONG, cyc, int'(MODE)});
  endtask

  task automatic do_reset();
    RESET  = 1'b1;
    KEY_IN = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Clean press held for 10 cycles then released for 10; expects a pulse at edge 7.
  task automatic press_release(input int new_mode);
    int t0;
    KEY_IN = 1'b0;
    t0 = cyc;
    exp_q.push_back('{EV_PRESS, t0 + DB + 3, new_mode});
    repeat (10) tick();
    KEY_IN = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    ev_t e, o;
    int  t0;
    RESET  = 1'b1;
    KEY_IN = 1'b0;
    repeat (3) tick();
    obs_q.delete();
    n_checks++;
    if (KEY_LEVEL !== 1'b0 || PRESS_PULSE !== 1'b0 || LONG_PRESS !== 1'b0 || MODE !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: level=%b pulse=%b long=%b mode=%0d, expected 0 0 0 0",
               KEY_LEVEL, PRESS_PULSE, LONG_PRESS, MODE);
    end
    RESET = 1'b0;
    t0 = cyc;
    exp_q.push_back('{EV_PRESS, t0 + 7, 1});
    repeat (10) tick();
    KEY_IN = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_event_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc || o.mode !== e.mode) begin
        n_fail++;
        $display("FAIL reset_event: got kind=%0d cyc=%0d mode=%0d, expected kind=%0d cyc=%0d mode=%0d",
                 o.kind, o.cyc, o.mode, e.kind, e.cyc, e.mode);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_clean_press();
    ev_t e, o;
    int  t0;
    do_reset();
    KEY_IN = 1'b0;
    t0 = cyc;
    exp_q.push_back('{EV_PRESS, t0 + DB + 3, 1});
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == DB + 2) begin
        n_checks++;
        if (KEY_LEVEL !== 1'b0 || MODE !== 2'd0) begin
          n_fail++;
          $display("FAIL press_early: level=%b mode=%0d at edge %0d, expected 0 0", KEY_LEVEL, MODE, i);
        end
      end
      if (i == DB + 3) begin
        n_checks++;
        if (KEY_LEVEL !== 1'b1 || MODE !== 2'd1) begin
          n_fail++;
          $display("FAIL press_level: level=%b mode=%0d at edge %0d, expected 1 1", KEY_LEVEL, MODE, i);
        end
      end
    end
    KEY_IN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == DB + 2) begin
        n_checks++;
        if (KEY_LEVEL !== 1'b1) begin
          n_fail++;
          $display("FAIL release_early: level=%b at edge %0d, expected 1", KEY_LEVEL, i);
        end
      end
      if (i == DB + 3) begin
        n_checks++;
        if (KEY_LEVEL !== 1'b0) begin
          n_fail++;
          $display("FAIL release_level: level=%b at edge %0d, expected 0", KEY_LEVEL, i);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL clean_event_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc || o.mode !== e.mode) begin
        n_fail++;
        $display("FAIL clean_event: got kind=%0d cyc=%0d mode=%0d, expected kind=%0d cyc=%0d mode=%0d",
                 o.kind, o.cyc, o.mode, e.kind, e.cyc, e.mode);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_bounce();
    ev_t e, o;
    int  t0;
    bit  level_held;
    do_reset();
    KEY_IN = 1'b0; repeat (3) tick();
    KEY_IN = 1'b1; repeat (1) tick();
    KEY_IN = 1'b0; repeat (2) tick();
    KEY_IN = 1'b1; repeat (10) tick();
    n_checks++;
    if (MODE !== 2'd0 || KEY_LEVEL !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_press: mode=%0d level=%b, expected 0 0", MODE, KEY_LEVEL);
    end
    KEY_IN = 1'b0;
    t0 = cyc;
    exp_q.push_back('{EV_PRESS, t0 + DB + 3, 1});
    repeat (10) tick();
    level_held = 1'b1;
    KEY_IN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (KEY_LEVEL !== 1'b1) level_held = 1'b0;
    end
    KEY_IN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (KEY_LEVEL !== 1'b1) level_held = 1'b0;
    end
    n_checks++;
    if (level_held !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_release_level: level dropped during release glitch, expected held at 1");
    end
    KEY_IN = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (KEY_LEVEL !== 1'b0 || MODE !== 2'd1) begin
      n_fail++;
      $display("FAIL bounce_final: level=%b mode=%0d, expected 0 1", KEY_LEVEL, MODE);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL bounce_event_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc || o.mode !== e.mode) begin
        n_fail++;
        $display("FAIL bounce_event: got kind=%0d cyc=%0d mode=%0d, expected kind=%0d cyc=%0d mode=%0d",
                 o.kind, o.cyc, o.mode, e.kind, e.cyc, e.mode);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_wrap();
    ev_t e, o;
    do_reset();
    for (int k = 0; k < 5; k++) press_release((k + 1) % NMODE);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_event_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc || o.mode !== e.mode) begin
        n_fail++;
        $display("FAIL wrap_event: got kind=%0d cyc=%0d mode=%0d, expected kind=%0d cyc=%0d mode=%0d",
                 o.kind, o.cyc, o.mode, e.kind, e.cyc, e.mode);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_long_press();
    ev_t e, o;
    int  t0;
    do_reset();
    press_release(1);
    press_release(2);
    n_checks++;
    if (MODE !== 2'd2) begin
      n_fail++;
      $display("FAIL long_setup_mode: mode=%0d, expected 2", MODE);
    end
    KEY_IN = 1'b0;
    t0 = cyc;
    exp_q.push_back('{EV_PRESS, t0 + DB + 3, 3});
    exp_q.push_back('{EV_LONG, t0 + DB + 3 + LONG, 0});
    repeat (40) tick();
    n_checks++;
    if (MODE !== 2'd0 || KEY_LEVEL !== 1'b1) begin
      n_fail++;
      $display("FAIL long_held: mode=%0d level=%b, expected 0 1", MODE, KEY_LEVEL);
    end
    KEY_IN = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (MODE !== 2'd0 || KEY_LEVEL !== 1'b0) begin
      n_fail++;
      $display("FAIL long_release: mode=%0d level=%b, expected 0 0", MODE, KEY_LEVEL);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL long_event_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc || o.mode !== e.mode) begin
        n_fail++;
        $display("FAIL long_event: got kind=%0d cyc=%0d mode=%0d, expected kind=%0d cyc=%0d mode=%0d",
                 o.kind, o.cyc, o.mode, e.kind, e.cyc, e.mode);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    int  t0;
    do_reset();
    press_release(1);
    KEY_IN = 1'b0;
    t0 = cyc;
    exp_q.push_back('{EV_PRESS, t0 + DB + 3, 2});
    repeat (10) tick();
    n_checks++;
    if (MODE !== 2'd2 || KEY_LEVEL !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: mode=%0d level=%b, expected 2 1", MODE, KEY_LEVEL);
    end
    RESET = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (MODE !== 2'd0 || KEY_LEVEL !== 1'b0 || PRESS_PULSE !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: mode=%0d level=%b pulse=%b, expected 0 0 0", MODE, KEY_LEVEL, PRESS_PULSE);
    end
    RESET = 1'b0;
    t0 = cyc;
    exp_q.push_back('{EV_PRESS, t0 + 7, 1});
    repeat (10) tick();
    n_checks++;
    if (MODE !== 2'd1 || KEY_LEVEL !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_repress: mode=%0d level=%b, expected 1 1", MODE, KEY_LEVEL);
    end
    KEY_IN = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL mid_event_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc || o.mode !== e.mode) begin
        n_fail++;
        $display("FAIL mid_event: got kind=%0d cyc=%0d mode=%0d, expected kind=%0d cyc=%0d mode=%0d",
                 o.kind, o.cyc, o.mode, e.kind, e.cyc, e.mode);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    RESET    = 1'b1;
    KEY_IN   = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_long_press();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
